// File: rtl/mem_arbiter.sv
// Shares one synchronous memory port between an instruction-fetch and a data port.
// Round-robin grant per cycle, registered command, tagged read-data return.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                i_req_i,
    input  logic [ADDR_W-1:0]   i_addr_i,
    output logic                i_gnt_o,
    output logic                i_rvalid_o,
    output logic [DATA_W-1:0]   i_rdata_o,
    input  logic                d_req_i,
    input  logic [DATA_W/8-1:0] d_we_i,
    input  logic [ADDR_W-1:0]   d_addr_i,
    input  logic [DATA_W-1:0]   d_wdata_i,
    output logic                d_gnt_o,
    output logic                d_rvalid_o,
    output logic [DATA_W-1:0]   d_rdata_o,
    output logic [ADDR_W-1:0]   m_addr_o,
    output logic [DATA_W-1:0]   m_wdata_o,
    output logic [DATA_W/8-1:0] m_we_o,
    output logic                m_rd_o,
    input  logic [DATA_W-1:0]   m_rdata_i
);
    localparam int BE_W = DATA_W / 8;

    logic              prio_q, prio_d;
    logic [ADDR_W-1:0] m_addr_q, m_addr_d;
    logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
    logic [BE_W-1:0]   m_we_q, m_we_d;
    logic              m_rd_q, m_rd_d;
    logic              cmd_d_q, cmd_d_d;
    logic              tag_v_q, tag_v_d;
    logic              tag_d_q, tag_d_d;

    // prio_q=1 means the instruction port won last, so data is preferred on a tie.
    always_comb begin
        i_gnt_o = ~rst_i & i_req_i & (~d_req_i | ~prio_q);
        d_gnt_o = ~rst_i & d_req_i & (~i_req_i |  prio_q);
    end

    always_comb begin
        prio_d    = prio_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        m_we_d    = '0;
        m_rd_d    = 1'b0;
        cmd_d_d   = d_gnt_o;
        if (i_gnt_o) begin
            prio_d   = 1'b1;
            m_addr_d = i_addr_i;
            m_rd_d   = 1'b1;
        end else if (d_gnt_o) begin
            prio_d   = 1'b0;
            m_addr_d = d_addr_i;
            if (d_we_i == '0) begin
                m_rd_d = 1'b1;
            end else begin
                m_we_d    = d_we_i;
                m_wdata_d = d_wdata_i;
            end
        end
        // Tag follows the command one stage later, aligned with the memory's read data.
        tag_v_d = m_rd_q;
        tag_d_d = cmd_d_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prio_q    <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            m_we_q    <= '0;
            m_rd_q    <= 1'b0;
            cmd_d_q   <= 1'b0;
            tag_v_q   <= 1'b0;
            tag_d_q   <= 1'b0;
        end else begin
            prio_q    <= prio_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            m_we_q    <= m_we_d;
            m_rd_q    <= m_rd_d;
            cmd_d_q   <= cmd_d_d;
            tag_v_q   <= tag_v_d;
            tag_d_q   <= tag_d_d;
        end
    end

    assign m_addr_o   = m_addr_q;
    assign m_wdata_o  = m_wdata_q;
    assign m_we_o     = m_we_q;
    assign m_rd_o     = m_rd_q;
    assign i_rvalid_o = tag_v_q & ~tag_d_q;
    assign d_rvalid_o = tag_v_q &  tag_d_q;
    assign i_rdata_o  = m_rdata_i;
    assign d_rdata_o  = m_rdata_i;
endmodule
